// File: rtl/ps2_keyboard_pkg.sv
// Shared peripheral definitions for the PS/2 keyboard controller:
// register offsets, STATUS bit layout and PS/2 frame constants.
package ps2_keyboard_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 11;  // start + 8 data + parity + stop
    localparam int unsigned BITCNT_W   = 3;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_ERR       = 3;
    localparam int unsigned ST_IRQ_EN    = 4;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       irq_en;
        logic       err;
        logic       ovf;
        logic       full;
        logic       not_empty;
    } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy/full/empty flags and a
// fall-through head output.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_n;

    // A pop frees a slot in the same cycle, so push is allowed when full if popping.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        count_n = count + CW'(do_push) - CW'(do_pop);
    end

    assign dout_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scancode FIFO and a 4-register CPU bus window.
// Frames are start/8 data LSB-first/odd parity/stop, sampled on PS/2 clock falls.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    inout  logic [7:0] data_bus,
    input  logic [1:0] address,
    input  logic       select,
    input  logic       read,
    input  logic       write,
    output logic       irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                clk_meta, clk_s, clk_prev;
    logic                data_meta, data_s;
    logic                fall_c;

    rx_state_e           state, state_n;
    logic [BITCNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]          shift, shift_n;
    logic                par_bit, par_n;
    logic [TW-1:0]       to_cnt, to_cnt_n;
    logic                push_c, frame_err_c;

    logic [7:0]          head_c;
    logic                full, empty;
    logic [CW-1:0]       count;

    logic                ovf, err, irq_en, rd_prev;
    logic                rd_now_c, pop_c, ovf_set_c, st_wr_c;
    logic [7:0]          rdata_c;
    status_t             status_c;

    // Two-flop synchronizers; idle-high bus state out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            clk_prev  <= clk_s;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    assign fall_c = clk_prev & ~clk_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par_bit <= par_n;
            to_cnt  <= to_cnt_n;
        end
    end

    // Receiver next-state: one bit per fall; a stalled frame is dropped silently.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        par_n       = par_bit;
        to_cnt_n    = '0;
        push_c      = 1'b0;
        frame_err_c = 1'b0;
        if (state != RX_IDLE) to_cnt_n = to_cnt + TW'(1);
        if (fall_c) begin
            to_cnt_n = '0;
            unique case (state)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                        shift_n   = '0;
                    end
                end
                RX_DATA: begin
                    shift_n   = {data_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + BITCNT_W'(1);
                    if (bit_cnt == BITCNT_W'(DATA_BITS - 1)) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_n   = data_s;
                    state_n = RX_STOP;
                end
                RX_STOP: begin
                    if (data_s && (^{shift, par_bit})) push_c = 1'b1;
                    else                               frame_err_c = 1'b1;
                    state_n   = RX_IDLE;
                    bit_cnt_n = '0;
                end
                default: state_n = RX_IDLE;
            endcase
        end else if ((state != RX_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            state_n   = RX_IDLE;
            to_cnt_n  = '0;
            bit_cnt_n = '0;
            shift_n   = '0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push   (push_c),
        .din    (shift),
        .pop    (pop_c),
        .dout_c (head_c),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // Pop only on the rising edge of a DATA read strobe.
    always_comb begin
        rd_now_c  = select & read & (address == REG_DATA);
        pop_c     = rd_now_c & ~rd_prev & ~empty;
        ovf_set_c = push_c & full & ~pop_c;
        st_wr_c   = select & write & (address == REG_STATUS);
    end

    always_comb begin
        status_c           = '0;
        status_c.not_empty = ~empty;
        status_c.full      = full;
        status_c.ovf       = ovf;
        status_c.err       = err;
        status_c.irq_en    = irq_en;
        rdata_c            = 8'h00;
        unique case (address)
            REG_DATA:   rdata_c = empty ? 8'h00 : head_c;
            REG_STATUS: rdata_c = status_c;
            REG_COUNT:  rdata_c = 8'(count);
            REG_RSVD:   rdata_c = 8'h00;
            default:    rdata_c = 8'h00;
        endcase
    end

    assign data_bus = (select & read) ? rdata_c : 8'bz;

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf     <= 1'b0;
            err     <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            if (st_wr_c) irq_en <= data_bus[ST_IRQ_EN];
            ovf     <= ovf_set_c   | (ovf & ~(st_wr_c & data_bus[ST_OVF]));
            err     <= frame_err_c | (err & ~(st_wr_c & data_bus[ST_ERR]));
            irq     <= ~empty & irq_en;
            rd_prev <= rd_now_c;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames and CPU bus cycles,
// checks register reads and irq against a queue-based model of the peripheral.
module tb_ps2_keyboard;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 50000;
    localparam int unsigned HALF  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [1:0] address;
    logic       select;
    logic       read;
    logic       write;
    logic       irq;
    wire  [7:0] data_bus;
    logic       drv_en;
    logic [7:0] drv_val;

    assign data_bus = drv_en ? drv_val : 8'bz;

    ps2_keyboard #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_bus (data_bus),
        .address  (address),
        .select   (select),
        .read     (read),
        .write    (write),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Peripheral model: scancode queue plus the three software-visible flags.
    logic [7:0] q [$];
    bit         m_ovf;
    bit         m_err;
    bit         m_irq_en;
    bit         settled;
    int         checks;
    int         failures;

    function automatic logic [7:0] model_reg(input logic [1:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            2'd0: v = (q.size() != 0) ? q[0] : 8'h00;
            2'd1: v = {3'b000, m_irq_en, m_err, m_ovf,
                       (q.size() == DEPTH), (q.size() != 0)};
            2'd2: v = 8'(q.size());
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (settled && reset)
            check("irq_model", 8'(irq), 8'(m_irq_en && (q.size() != 0)));
    end

    task automatic bus_read(input logic [1:0] a, input logic [7:0] lit,
                            input string name, input int hold);
        logic [7:0] got;
        logic [7:0] mexp;
        settled = 1'b0;
        @(negedge clk);
        select  = 1'b1;
        read    = 1'b1;
        address = a;
        #1;
        got  = data_bus;
        mexp = model_reg(a);
        check({name, "/model"}, got, mexp);
        check({name, "/lit"},   got, lit);
        if (a == 2'd0 && q.size() != 0) void'(q.pop_front());
        repeat (hold) @(negedge clk);
        select = 1'b0;
        read   = 1'b0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
        settled = 1'b0;
        @(negedge clk);
        select  = 1'b1;
        write   = 1'b1;
        address = a;
        drv_en  = 1'b1;
        drv_val = v;
        @(negedge clk);
        select = 1'b0;
        write  = 1'b0;
        drv_en = 1'b0;
        if (a == 2'd1) begin
            m_irq_en = v[4];
            if (v[2]) m_ovf = 1'b0;
            if (v[3]) m_err = 1'b0;
        end
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    // bits[0] goes on the wire first.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        settled = 1'b0;
        par = ~(^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        repeat (4) @(negedge clk);
        if (!bad_par && !bad_stop) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else                   q.push_back(b);
        end else begin
            m_err = 1'b1;
        end
        settled = 1'b1;
    endtask

    task automatic do_reset();
        settled  = 1'b0;
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_irq", 8'(irq), 8'h00);
        reset = 1'b1;
        q.delete();
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_irq_en = 1'b0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        settled  = 1'b0;
        select   = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        address  = 2'd0;
        drv_en   = 1'b0;
        drv_val  = 8'h00;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_irq_en = 1'b0;
        do_reset();

        // Reset state and empty-FIFO reads
        bus_read(2'd1, 8'h00, "rst_status", 1);
        bus_read(2'd2, 8'h00, "rst_count", 1);
        bus_read(2'd0, 8'h00, "empty_data", 1);
        bus_read(2'd3, 8'h00, "rsvd_reg", 1);

        // Good frame
        send_frame(8'h1C, 1'b0, 1'b0);
        bus_read(2'd2, 8'h01, "f1c_count", 1);
        bus_read(2'd1, 8'h01, "f1c_status", 1);
        bus_read(2'd0, 8'h1C, "f1c_data", 1);
        bus_read(2'd1, 8'h00, "f1c_status_after", 1);

        // Parity error, then stop-bit error
        send_frame(8'h1C, 1'b1, 1'b0);
        bus_read(2'd2, 8'h00, "perr_count", 1);
        bus_read(2'd1, 8'h08, "perr_status", 1);
        bus_write(2'd1, 8'h08);
        bus_read(2'd1, 8'h00, "perr_cleared", 1);
        send_frame(8'h55, 1'b0, 1'b1);
        bus_read(2'd1, 8'h08, "serr_status", 1);
        bus_write(2'd1, 8'h08);

        // Overflow: nine frames into eight slots
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        bus_read(2'd2, 8'h08, "ovf_count", 1);
        bus_read(2'd1, 8'h07, "ovf_status", 1);
        for (int i = 1; i <= 8; i++) bus_read(2'd0, 8'(i), "ovf_drain", 1);
        bus_read(2'd1, 8'h04, "ovf_sticky", 1);
        bus_write(2'd1, 8'h04);
        bus_read(2'd1, 8'h00, "ovf_cleared", 1);

        // Interrupt and held-strobe single pop
        bus_write(2'd1, 8'h10);
        bus_read(2'd1, 8'h10, "irqen_status", 1);
        check("irq_before", 8'(irq), 8'h00);
        send_frame(8'hF0, 1'b0, 1'b0);
        check("irq_after_push", 8'(irq), 8'h01);
        bus_read(2'd1, 8'h11, "irq_status", 1);
        send_frame(8'hA5, 1'b0, 1'b0);
        bus_read(2'd0, 8'hF0, "held_read", 5);
        bus_read(2'd2, 8'h01, "held_count", 1);
        check("irq_still_one", 8'(irq), 8'h01);
        bus_read(2'd0, 8'hA5, "held_read2", 5);
        check("irq_low", 8'(irq), 8'h00);
        bus_read(2'd2, 8'h00, "held_count0", 1);
        bus_write(2'd1, 8'h00);

        // Timeout of a stalled frame
        settled = 1'b0;
        send_bits(11'b1010, 4);
        settled = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        bus_read(2'd1, 8'h00, "tmo_status", 1);
        bus_read(2'd2, 8'h00, "tmo_count", 1);
        send_frame(8'h5A, 1'b0, 1'b0);
        bus_read(2'd2, 8'h01, "tmo_next_count", 1);
        bus_read(2'd0, 8'h5A, "tmo_next_data", 1);

        // Reset mid-frame with a partly filled FIFO
        bus_write(2'd1, 8'h10);
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        bus_read(2'd2, 8'h02, "pre_rst_count", 1);
        settled = 1'b0;
        send_bits(11'b01100, 5);
        do_reset();
        bus_read(2'd2, 8'h00, "post_rst_count", 1);
        bus_read(2'd1, 8'h00, "post_rst_status", 1);
        check("post_rst_irq", 8'(irq), 8'h00);
        send_frame(8'h33, 1'b0, 1'b0);
        bus_read(2'd2, 8'h01, "post_rst_next_count", 1);
        bus_read(2'd0, 8'h33, "post_rst_next_data", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, scancode FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a PS/2 clock fall before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  PS/2 clock from keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 data from keyboard, asynchronous to clk.
REQ-007 data_bus  inout  8  shared CPU data bus; driven only while select & read, else high-Z.
REQ-008 address  input  2  register offset within the peripheral window.
REQ-009 select  input  1  peripheral chip select from the board address decode.
REQ-010 read  input  1  CPU read strobe.
REQ-011 write  input  1  CPU write strobe.
REQ-012 irq  output  1  high while FIFO non-empty and irq enable set.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; a fall is a synced 1->0 transition of ps2_clk vs. its previous synced value.
REQ-014 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP, sampling synced ps2_data once per fall.
REQ-015 IDLE: fall with data 0 (start) -> DATA, bit counter 0; fall with data 1 -> stay IDLE.
REQ-016 DATA: shift data in LSB first; after 8th bit -> PARITY.
REQ-017 PARITY: store bit -> STOP; odd parity over 8 data bits + parity bit required.
REQ-018 STOP: on fall, if stop bit 1 and parity good, push byte to FIFO; else set sticky ERR, discard; both -> IDLE.
REQ-019 In any state except IDLE, TIMEOUT_CYCLES clk cycles without a fall SHALL return FSM to IDLE, discarding partial byte, without setting ERR.
REQ-020 Register map: 0 DATA (R), 1 STATUS (R/W), 2 COUNT (R), 3 reads 0x00, writes ignored.
REQ-021 STATUS bits: 0 NOT_EMPTY, 1 FULL, 2 OVF (sticky), 3 ERR (sticky), 4 IRQ_EN, 7:5 read 0.
REQ-022 Write to STATUS: IRQ_EN <= data_bus[4]; a 1 on bit 2 or 3 clears OVF or ERR respectively; other bits ignored.
REQ-023 Read data SHALL be combinational from registered state while select & read high.
REQ-024 A pop SHALL occur on the single clk edge where select & read & address==0 is high and was low the previous cycle; a held strobe pops once.
REQ-025 DATA read while empty returns 0x00, no pop, no state change.
REQ-026 COUNT returns occupancy 0..FIFO_DEPTH, zero-extended.
REQ-027 Push while full with no same-cycle pop: byte dropped, OVF set, FIFO unchanged.
REQ-028 Push and pop in same cycle: pop head, push tail, count unchanged, no OVF even if full.
REQ-029 Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-030 irq SHALL be registered, one cycle after NOT_EMPTY & IRQ_EN change.

Reset
REQ-031 reset low SHALL force immediately: FSM IDLE, bit counter 0, shift reg 0, timeout counter 0, FIFO empty, pointers 0, OVF 0, ERR 0, IRQ_EN 0, irq 0, synchronizers 1 (bus idle), read-edge history 0, data_bus high-Z.
REQ-032 Reset mid-frame discards the partial byte; reception restarts at the next start bit after release.

Structure
REQ-033 Register offsets, STATUS bit indices and the frame length constant SHALL live in the shared peripheral package.
REQ-034 FIFO SHALL be sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count, async active-low reset); receiver FSM and bus interface stay in ps2_keyboard.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1 -> COUNT=1, STATUS=0x01; DATA read returns 0x1C; then STATUS=0x00.
REQ-036 Frame 0x1C with parity 1 -> FIFO empty, STATUS=0x08; write 0x08 to STATUS -> STATUS=0x00.
REQ-037 9 valid frames 0x01..0x09, no reads, depth 8 -> COUNT=8, STATUS=0x07; reads return 0x01..0x08 in order.
REQ-038 IRQ_EN=1, one frame 0xF0 -> irq high one cycle after push; read held 5 cycles pops once, irq low, COUNT=0.
REQ-039 Start bit + 3 data bits, then 50000 idle cycles -> FSM IDLE, STATUS=0x00; next full frame 0x5A received correctly.
REQ-040 Assert reset mid-frame after 4 data bits with FIFO holding 2 bytes -> COUNT=0, STATUS=0x00, irq 0; next frame 0x33 received correctly.
